// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard of in-flight destinations,
// operand forwarding selects, load-use/busy stalls, branch flush and debug stepping.
module hazard_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int PIPE_DEPTH  = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic [ADDR_W-1:0]                  id_rs,
    input  logic [ADDR_W-1:0]                  id_rt,
    input  logic                               id_rs_used,
    input  logic                               id_rt_used,
    input  logic                               id_wen,
    input  logic [ADDR_W-1:0]                  id_rd,
    input  logic                               id_is_load,
    input  logic                               id_branch_taken,
    input  logic                               exe_busy,
    input  logic                               debug_en,
    input  logic                               debug_step,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]    fwd_a_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]    fwd_b_sel,
    output logic [PIPE_DEPTH+1:0]              stage_en,
    output logic [PIPE_DEPTH+1:0]              stage_rst,
    output logic                               stall,
    output logic [CNT_W-1:0]                   stall_cycles
);

    localparam int SEL_W = $clog2(PIPE_DEPTH + 1);
    localparam int FCW   = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS + 1) : 1;

    logic [PIPE_DEPTH:1]             sb_valid;
    logic [PIPE_DEPTH:1]             sb_wen;
    logic [PIPE_DEPTH:1]             sb_load;
    logic [PIPE_DEPTH:1][ADDR_W-1:0] sb_rd;
    logic [FCW-1:0]                  flush_cnt;
    logic                            step_prev;

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             hold, load_use, taken_issue, flush;

    // Youngest matching producer wins; address 0 is hardwired and never forwards.
    function automatic logic [SEL_W-1:0] fwd_pick(
        input logic [ADDR_W-1:0]             src,
        input logic                          used,
        input logic [PIPE_DEPTH:1]           v,
        input logic [PIPE_DEPTH:1]           w,
        input logic [PIPE_DEPTH:1][ADDR_W-1:0] rd
    );
        fwd_pick = '0;
        if (used && src != '0) begin
            for (int k = PIPE_DEPTH; k >= 1; k--) begin
                if (v[k] && w[k] && rd[k] == src) fwd_pick = SEL_W'(k);
            end
        end
    endfunction

    always_comb begin
        sel_a = fwd_pick(id_rs, id_rs_used, sb_valid, sb_wen, sb_rd);
        sel_b = fwd_pick(id_rt, id_rt_used, sb_valid, sb_wen, sb_rd);
        load_use = 1'b0;
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            if (sb_load[k] && k <= LOAD_LAT && (sel_a == SEL_W'(k) || sel_b == SEL_W'(k)))
                load_use = id_valid;
        end
        hold        = debug_en && !(debug_step && !step_prev);
        taken_issue = id_valid && id_branch_taken;
        flush       = (flush_cnt != '0) || taken_issue;
    end

    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        stall     = 1'b0;
        fwd_a_sel = sel_a;
        fwd_b_sel = sel_b;
        if (rst) begin
            stage_rst = '1;
            fwd_a_sel = '0;
            fwd_b_sel = '0;
        end else if (hold) begin
            stage_en = '0;
        end else if (exe_busy) begin
            stage_en[2:0] = '0;
            stage_rst[3]  = 1'b1;
            stall         = 1'b1;
        end else if (load_use) begin
            stage_en[1:0] = '0;
            stage_rst[2]  = 1'b1;
            stall         = 1'b1;
        end else if (flush) begin
            stage_rst[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid     <= '0;
            sb_wen       <= '0;
            sb_load      <= '0;
            sb_rd        <= '0;
            flush_cnt    <= '0;
            stall_cycles <= '0;
            step_prev    <= 1'b0;
        end else begin
            step_prev <= debug_step;
            if (!hold) begin
                if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
                for (int k = PIPE_DEPTH; k >= 2; k--) begin
                    sb_valid[k] <= sb_valid[k-1];
                    sb_wen[k]   <= sb_wen[k-1];
                    sb_load[k]  <= sb_load[k-1];
                    sb_rd[k]    <= sb_rd[k-1];
                end
                if (exe_busy) begin
                    // EXE occupant stays put; a bubble drains into the stage after it
                    sb_valid[1] <= sb_valid[1];
                    sb_wen[1]   <= sb_wen[1];
                    sb_load[1]  <= sb_load[1];
                    sb_rd[1]    <= sb_rd[1];
                    sb_valid[2] <= 1'b0;
                    sb_wen[2]   <= 1'b0;
                    sb_load[2]  <= 1'b0;
                    sb_rd[2]    <= '0;
                end else if (load_use) begin
                    sb_valid[1] <= 1'b0;
                    sb_wen[1]   <= 1'b0;
                    sb_load[1]  <= 1'b0;
                    sb_rd[1]    <= '0;
                end else begin
                    sb_valid[1] <= id_valid;
                    sb_wen[1]   <= id_wen;
                    sb_load[1]  <= id_is_load;
                    sb_rd[1]    <= id_rd;
                    if (flush) flush_cnt <= taken_issue ? FCW'(FLUSH_SLOTS - 1) : flush_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int D  = 3;
    localparam int LL = 1;
    localparam int FS = 2;
    localparam int CW = 4;
    localparam int NS = D + 2;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, id_branch_taken;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic exe_busy, debug_en, debug_step;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [NS-1:0] stage_en, stage_rst;
    logic stall;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    hazard_ctrl #(.ADDR_W(AW), .PIPE_DEPTH(D), .LOAD_LAT(LL), .FLUSH_SLOTS(FS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wen(id_wen), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_branch_taken(id_branch_taken), .exe_busy(exe_busy),
        .debug_en(debug_en), .debug_step(debug_step), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stage_en(stage_en), .stage_rst(stage_rst), .stall(stall),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {bit v; bit w; bit [AW-1:0] rd; bit ld;} rec_t;
    localparam rec_t BUBBLE = '0;
    rec_t pipe[$];          // pipe[0] is the instruction in EXE
    int   m_flush = 0;
    int   m_cnt   = 0;
    bit   m_prev  = 1'b0;

    typedef enum int {M_RST, M_HOLD, M_BUSY, M_LU, M_FLUSH, M_NORM} mode_t;

    function automatic int pick(input bit [AW-1:0] x, input bit used);
        if (!used || x == 0) return 0;
        foreach (pipe[i]) if (pipe[i].v && pipe[i].w && pipe[i].rd == x) return i + 1;
        return 0;
    endfunction

    function automatic bit lu_on(input int k);
        return k != 0 && k <= LL && pipe[k-1].ld;
    endfunction

    function automatic mode_t mode();
        if (rst) return M_RST;
        if (debug_en && !(debug_step && !m_prev)) return M_HOLD;
        if (exe_busy) return M_BUSY;
        if (id_valid && (lu_on(pick(id_rs, id_rs_used)) || lu_on(pick(id_rt, id_rt_used)))) return M_LU;
        if (m_flush != 0 || (id_valid && id_branch_taken)) return M_FLUSH;
        return M_NORM;
    endfunction

    initial for (int i = 0; i < D; i++) pipe.push_back(BUBBLE);

    always @(posedge clk) begin
        mode_t m;
        rec_t r;
        m = mode();
        if (m == M_RST) begin
            pipe.delete();
            for (int i = 0; i < D; i++) pipe.push_back(BUBBLE);
            m_flush = 0; m_cnt = 0; m_prev = 1'b0;
        end else begin
            m_prev = debug_step;
            if (m == M_BUSY || m == M_LU) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
            if (m == M_BUSY) begin
                pipe.insert(1, BUBBLE);
                void'(pipe.pop_back());
            end else if (m == M_LU) begin
                pipe.push_front(BUBBLE);
                void'(pipe.pop_back());
            end else if (m != M_HOLD) begin
                r.v = id_valid; r.w = id_wen; r.rd = id_rd; r.ld = id_is_load;
                pipe.push_front(r);
                void'(pipe.pop_back());
                if (m == M_FLUSH) m_flush = (id_valid && id_branch_taken) ? FS - 1 : m_flush - 1;
            end
        end
        started = 1'b1;
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mode_t m;
            int ea, eb, en, er, es;
            m = mode();
            ea = (m == M_RST) ? 0 : pick(id_rs, id_rs_used);
            eb = (m == M_RST) ? 0 : pick(id_rt, id_rt_used);
            en = (1 << NS) - 1; er = 0; es = 0;
            case (m)
                M_RST:   er = (1 << NS) - 1;
                M_HOLD:  en = 0;
                M_BUSY:  begin en = en & ~32'h7; er = 32'h8; es = 1; end
                M_LU:    begin en = en & ~32'h3; er = 32'h4; es = 1; end
                M_FLUSH: er = 32'h2;
                default: ;
            endcase
            cmp("model_fwd_a", fwd_a_sel, ea);
            cmp("model_fwd_b", fwd_b_sel, eb);
            cmp("model_stage_en", stage_en, en);
            cmp("model_stage_rst", stage_rst, er);
            cmp("model_stall", stall, es);
            cmp("model_stall_cycles", stall_cycles, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_wen = 0;
        id_rd = 0; id_is_load = 0; id_branch_taken = 0; exe_busy = 0; debug_en = 0; debug_step = 0;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic issue(input bit [AW-1:0] rd, input bit ld);
        idle(); id_valid = 1; id_wen = 1; id_rd = rd; id_is_load = ld;
    endtask

    initial begin
        int rel;
        rst = 1; idle();
        @(negedge clk);
        cmp("rst_stage_rst", stage_rst, 5'b11111);
        cmp("rst_stage_en", stage_en, 5'b11111);
        cmp("rst_stall", stall, 0);
        cmp("rst_fwd_a", fwd_a_sel, 0);
        adv(); rst = 0;

        // back-to-back dependency
        issue(3, 0); adv();
        issue(4, 0); id_rs = 3; id_rs_used = 1;
        @(negedge clk); cmp("b2b_fwd_a", fwd_a_sel, 1); adv();
        idle(); id_valid = 1; id_rt = 3; id_rt_used = 1;
        @(negedge clk); cmp("b2b_fwd_b", fwd_b_sel, 2); adv();
        issue(0, 0); adv();
        idle(); id_valid = 1; id_rs = 0; id_rs_used = 1;
        @(negedge clk); cmp("rd0_fwd_a", fwd_a_sel, 0); adv();
        idle(); adv(); adv(); adv();

        // load-use with defaults
        issue(5, 1); adv();
        idle(); id_valid = 1; id_rs = 5; id_rs_used = 1;
        @(negedge clk);
        cmp("lu_stall", stall, 1);
        cmp("lu_en10", stage_en[1:0], 0);
        cmp("lu_rst2", stage_rst[2], 1);
        adv();
        @(negedge clk);
        cmp("lu_after_stall", stall, 0);
        cmp("lu_after_fwd_a", fwd_a_sel, 2);
        cmp("lu_after_cnt", stall_cycles, 1);
        adv(); idle(); adv(); adv(); adv();

        // taken branch, two flush slots
        idle(); id_valid = 1; id_branch_taken = 1;
        @(negedge clk); cmp("br_slot0", stage_rst[1], 1); adv();
        idle(); @(negedge clk); cmp("br_slot1", stage_rst[1], 1); adv();
        @(negedge clk); cmp("br_done", stage_rst[1], 0); adv();

        // taken branch blocked by a load-use stall
        issue(6, 1); adv();
        idle(); id_valid = 1; id_rs = 6; id_rs_used = 1; id_branch_taken = 1;
        @(negedge clk); cmp("brlu_stall", stall, 1); cmp("brlu_noflush", stage_rst[1], 0); adv();
        @(negedge clk); cmp("brlu_issue", stage_rst[1], 1); adv();
        idle(); @(negedge clk); cmp("brlu_slot1", stage_rst[1], 1); adv();
        @(negedge clk); cmp("brlu_done", stage_rst[1], 0); adv();

        // exe_busy for three cycles from a fresh counter
        rst = 1; adv(); rst = 0;
        issue(7, 0); adv();
        for (int c = 0; c < 3; c++) begin
            idle(); exe_busy = 1; id_valid = 1; id_rs = 7; id_rs_used = 1;
            @(negedge clk);
            cmp("busy_en20", stage_en[2:0], 0);
            cmp("busy_rst3", stage_rst[3], 1);
            cmp("busy_fwd_a", fwd_a_sel, 1);
            adv();
        end
        exe_busy = 0;
        @(negedge clk);
        cmp("busy_cnt", stall_cycles, 3);
        cmp("busy_release_fwd", fwd_a_sel, 1);
        adv(); idle(); adv(); adv(); adv();

        // debug hold and single step
        idle(); debug_en = 1;
        @(negedge clk); cmp("dbg_hold_en", stage_en, 0); adv();
        rel = 0; debug_step = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (stage_en == 5'b11111) rel++;
            adv();
        end
        cmp("dbg_step_releases", rel, 1);
        rst = 1;
        @(negedge clk); cmp("dbg_rst_stage_rst", stage_rst, 5'b11111); cmp("dbg_rst_en", stage_en, 5'b11111);
        adv(); rst = 0; idle(); adv();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 99) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = AW'($urandom_range(0, 7));
            id_rt           = AW'($urandom_range(0, 7));
            id_rs_used      = $urandom_range(0, 1);
            id_rt_used      = $urandom_range(0, 1);
            id_wen          = ($urandom_range(0, 3) != 0);
            id_rd           = AW'($urandom_range(0, 7));
            id_is_load      = ($urandom_range(0, 3) == 0);
            id_branch_taken = ($urandom_range(0, 7) == 0);
            exe_busy        = ($urandom_range(0, 7) == 0);
            debug_en        = ($urandom_range(0, 9) == 0);
            debug_step      = $urandom_range(0, 1);
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the MIPS pipelined CPU, succeeding the fixed 5-stage controller's stall and forwarding logic. It sits beside the ID stage and holds a shadow scoreboard of in-flight destination registers for every stage downstream of ID. From that scoreboard it generates forwarding selects for both source operands, load-use stalls, multi-cycle EXE freezes, branch flush slots and debug single-step gating. All stage enables and resets come out as one-per-stage vectors, so the same block serves deeper pipelines.

## Interface
- ADDR_W, 5, register address width
- PIPE_DEPTH, 3, number of stages after ID (stage 1 = EXE … stage PIPE_DEPTH = WB); minimum 2
- LOAD_LAT, 1, stages a load spends past EXE before its data can be forwarded
- FLUSH_SLOTS, 1, wrong-path slots killed per taken branch; minimum 1
- CNT_W, 16, width of stall counter
- clk  in  1  main clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  ADDR_W each  ID source addresses
- id_rs_used, id_rt_used  in  1 each  source actually read
- id_wen  in  1  ID instruction writes a register
- id_rd  in  ADDR_W  final destination address (RD/RT/31 already resolved)
- id_is_load  in  1  ID instruction is a load
- id_branch_taken  in  1  ID resolved a taken branch or jump
- exe_busy  in  1  multi-cycle EXE unit not yet done
- debug_en, debug_step  in  1 each  debug hold; step on debug_step rising edge
- fwd_a_sel, fwd_b_sel  out  $clog2(PIPE_DEPTH+1)  0 = register file, k = result bus of stage k
- stage_en  out  PIPE_DEPTH+2  per-stage enable; bit 0 = IF, bit 1 = ID, bit 2 = EXE, …
- stage_rst  out  PIPE_DEPTH+2  per-stage reset/bubble, same indexing
- stall  out  1  load-use or busy stall this cycle
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: entries sb[1..PIPE_DEPTH], each {valid, wen, rd, is_load}. sb[k] mirrors the instruction now in stage k.
- Forwarding for operand X (rs or rt):
  - Pick the smallest k with sb[k].valid & wen & rd==X and X != 0.
  - If X is not used or there is no match, select 0. Address 0 never forwards.
- Load-use hazard: the chosen k has is_load and k ≤ LOAD_LAT, on either used operand, while id_valid.
- Priority, highest first. Each case lists the stages not left at their default; all other stage_en bits stay 1 and all other stage_rst bits stay 0.
  1. rst:
     - stage_rst = all 1s, stage_en = all 1s.
     - Scoreboard cleared, flush counter = 0, stall_cycles = 0, step edge register = 0.
  2. Debug hold, when debug_en & !(debug_step & !step_prev):
     - stage_en = 0, stage_rst = 0.
     - Scoreboard, counters and flush count are frozen.
  3. exe_busy:
     - stage_en[2:0] = 0, stage_rst[3] = 1.
     - Scoreboard: sb[1] holds; sb[k] ← sb[k-1] for k ≥ 3; sb[2] ← bubble.
     - stall = 1.
  4. Load-use:
     - stage_en[1:0] = 0, stage_rst[2] = 1.
     - Scoreboard: sb[1] ← bubble, the rest shift.
     - stall = 1. id_branch_taken is ignored.
  5. Flush, active when flush_cnt != 0, or when id_branch_taken & id_valid issues this cycle:
     - stage_rst[1] = 1.
     - On a taken issue, flush_cnt ← FLUSH_SLOTS-1; otherwise flush_cnt decrements.
     - Shift as normal.
  6. Normal:
     - stage_en = all 1s, stage_rst = 0.
     - sb[1] ← {id_valid, id_wen, id_rd, id_is_load}; sb[k] ← sb[k-1].
- stall_cycles increments on every cycle with stall = 1 and saturates at all 1s.

## Timing
- All outputs except stall_cycles are combinational from inputs and state.
- Scoreboard, flush_cnt, stall_cycles and step_prev update on the clk rising edge.
- Reset values:
  - Outputs: stage_rst all 1s, stage_en all 1s, fwd selects 0, stall 0.
  - State: stall_cycles 0 after the reset edge; scoreboard invalid.
- Load-use stall lasts LOAD_LAT-k+1 cycles for a producer at stage k. With defaults: one bubble, then fwd sel = 2.
- Flush with defaults kills exactly one IF slot, in the same cycle as id_branch_taken.
- Debug step releases exactly one cycle per debug_step rising edge; a held-high step releases only one.
- Simultaneous busy and load-use: busy wins. The load-use check is re-evaluated after busy drops.

## Test plan
- Back-to-back dependency:
  - Stimulus: add r3 issues, then id_rs = 3 next cycle.
  - Required: fwd_a_sel = 1. One cycle later, with id_rt = 3: fwd_b_sel = 2.
  - Edge case: id_rd = 0 producer → sel 0.
- Load-use, defaults:
  - Stimulus: load r5 issues, then id_rs = 5.
  - Required: stall = 1 for one cycle, stage_en[1:0] = 0, stage_rst[2] = 1.
  - Required next cycle: fwd_a_sel = 2 and stall_cycles = 1.
- Branch with FLUSH_SLOTS = 2:
  - Stimulus: id_branch_taken with id_valid.
  - Required: stage_rst[1] = 1 for exactly 2 consecutive cycles.
  - Stimulus: the same during a load-use stall.
  - Required: no flush until the instruction issues.
- exe_busy held for 3 cycles:
  - Required: stage_en[2:0] = 0 and stage_rst[3] = 1 for 3 cycles.
  - Required: a producer at sb[1] stays matched as sel 1; stall_cycles = 3.
- Debug:
  - Stimulus: debug_en = 1, debug_step held high for 4 cycles.
  - Required: exactly one cycle with stage_en all 1s.
  - Required: rst during debug hold still gives stage_rst all 1s.
